hsi_video_top: RTL and testbench



---
 rtl/hsi_video_pkg.sv | 27 ++
 rtl/hsi_video_rgb2hsi.sv | 111 +++++++++++
 rtl/hsi_video_top.sv | 80 ++++++++
 tb/tb_hsi_video_top.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hsi_video_pkg.sv
// Shared constants and types for the HSI video source: default raster timing,
// pipeline latency and hue sector offsets.
package hsi_video_pkg;
  localparam int H_DISP_D  = 400;
  localparam int V_DISP_D  = 306;
  localparam int H_SYNC_D  = 40;
  localparam int H_BACK_D  = 20;
  localparam int H_FRONT_D = 20;
  localparam int V_SYNC_D  = 2;
  localparam int V_BACK_D  = 4;
  localparam int V_FRONT_D = 4;

  localparam int PIPE_LAT = 4;

  localparam logic [15:0] HUE_STEP = 16'd43;
  localparam logic [7:0]  HUE_G    = 8'd85;
  localparam logic [7:0]  HUE_B    = 8'd171;

  typedef enum logic [1:0] {SEL_R, SEL_G, SEL_B} max_sel_t;

  // Ties resolve toward R, then G.
  function automatic max_sel_t max_sel(input logic [7:0] r, g, b);
    if (r >= g && r >= b) return SEL_R;
    else if (g >= b)      return SEL_G;
    else                  return SEL_B;
  endfunction
endpackage

// File: rtl/hsi_video_rgb2hsi.sv
// Four-stage RGB888 -> HSI converter; data is forced to zero when invalid.
// HSI_BYPASS_EN: pass the RGB input through with the same latency instead.
module hsi_video_rgb2hsi
  import hsi_video_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic [23:0] pix_rgb,
  output logic        hsi_valid,
  output logic [23:0] hsi
);
  logic [PIPE_LAT-2:0] vld_pipe;

  logic [7:0] r, g, b, mx, mn;
  max_sel_t   sel;

  logic [7:0]  s1_max, s1_min;
  logic [9:0]  s1_sum;
  max_sel_t    s1_sel;
  logic [7:0]  s1_r, s1_g, s1_b;

  logic [9:0]         s2_sum;
  logic [17:0]        s2_snum;
  logic signed [15:0] s2_hnum;
  logic [7:0]         s2_delta, s2_base;

  logic [7:0] s3_h, s3_s, s3_i;

  logic [8:0]         diff;
  logic [7:0]         base;
  logic [15:0]        hnum;
  logic [9:0]         smin3;
  logic [17:0]        snum;
  logic signed [15:0] hq;
  logic [7:0]         h_c, s_c, i_c;

  assign r = pix_rgb[23:16];
  assign g = pix_rgb[15:8];
  assign b = pix_rgb[7:0];

  always_comb begin
    sel = max_sel(r, g, b);
    mx  = (sel == SEL_R) ? r : (sel == SEL_G) ? g : b;
    mn  = (r <= g && r <= b) ? r : (g <= b) ? g : b;
  end

  // Hue numerator: 9-bit two's-complement difference, sign-extended before scaling.
  always_comb begin
    diff = '0;
    base = '0;
    case (s1_sel)
      SEL_R:   begin diff = 9'(s1_g) - 9'(s1_b); base = 8'd0;  end
      SEL_G:   begin diff = 9'(s1_b) - 9'(s1_r); base = HUE_G; end
      default: begin diff = 9'(s1_r) - 9'(s1_g); base = HUE_B; end
    endcase
    hnum  = {{7{diff[8]}}, diff} * HUE_STEP;
    smin3 = 10'(s1_min) * 10'd3;
    snum  = 18'(s1_sum - smin3) * 18'd255;
  end

  always_comb begin
    i_c = 8'(s2_sum / 10'd3);
    s_c = '0;
    h_c = '0;
    hq  = '0;
    if (s2_sum != '0) s_c = 8'(s2_snum / 18'(s2_sum));
    if (s2_delta != '0) begin
      hq  = s2_hnum / $signed({8'd0, s2_delta});
      h_c = s2_base + 8'(hq);
    end
  end

`ifdef HSI_BYPASS_EN
  logic [PIPE_LAT-2:0][23:0] byp_pipe;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) byp_pipe <= '0;
    else        byp_pipe <= {byp_pipe[PIPE_LAT-3:0], pix_rgb};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      s1_max    <= '0; s1_min <= '0; s1_sum <= '0; s1_sel <= SEL_R;
      s1_r      <= '0; s1_g   <= '0; s1_b   <= '0;
      s2_sum    <= '0; s2_snum <= '0; s2_hnum <= '0; s2_delta <= '0; s2_base <= '0;
      s3_h      <= '0; s3_s   <= '0; s3_i   <= '0;
      hsi_valid <= 1'b0;
      hsi       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE_LAT-3:0], pix_valid};
      s1_max   <= mx;
      s1_min   <= mn;
      s1_sum   <= 10'(r) + 10'(g) + 10'(b);
      s1_sel   <= sel;
      s1_r     <= r; s1_g <= g; s1_b <= b;
      s2_sum   <= s1_sum;
      s2_snum  <= snum;
      s2_hnum  <= hnum;
      s2_delta <= s1_max - s1_min;
      s2_base  <= base;
      s3_h     <= h_c; s3_s <= s_c; s3_i <= i_c;
      hsi_valid <= vld_pipe[PIPE_LAT-2];
`ifdef HSI_BYPASS_EN
      hsi <= vld_pipe[PIPE_LAT-2] ? byp_pipe[PIPE_LAT-2] : '0;
`else
      hsi <= vld_pipe[PIPE_LAT-2] ? {s3_h, s3_s, s3_i} : '0;
`endif
    end
  end
endmodule

// File: rtl/hsi_video_top.sv
// VGA-style raster generator with coordinate test pattern, converted to HSI.
// HSI_BYPASS_EN: output the raw RGB pattern instead (same 4-clock latency).
module hsi_video_top
  import hsi_video_pkg::*;
#(
  parameter int H_DISP  = H_DISP_D,
  parameter int V_DISP  = V_DISP_D,
  parameter int H_SYNC  = H_SYNC_D,
  parameter int H_BACK  = H_BACK_D,
  parameter int H_FRONT = H_FRONT_D,
  parameter int V_SYNC  = V_SYNC_D,
  parameter int V_BACK  = V_BACK_D,
  parameter int V_FRONT = V_FRONT_D
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        VGA_hsync,
  output logic        VGA_vsync,
  output logic [23:0] VGA_data,
  output logic        VGA_de
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  logic [HCW-1:0] h_cnt;
  logic [VCW-1:0] v_cnt;
  logic           hs_raw, vs_raw, de_raw;
  logic [7:0]     x8, y8;
  logic [23:0]    rgb;
  logic [PIPE_LAT-1:0] hs_pipe, vs_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HCW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VCW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // Only the low 8 bits of the active coordinates feed the pattern.
  always_comb begin
    hs_raw = !(h_cnt < HCW'(H_SYNC));
    vs_raw = !(v_cnt < VCW'(V_SYNC));
    de_raw = (h_cnt >= HCW'(HA)) && (h_cnt < HCW'(HA + H_DISP)) &&
             (v_cnt >= VCW'(VA)) && (v_cnt < VCW'(VA + V_DISP));
    x8     = 8'(h_cnt - HCW'(HA));
    y8     = 8'(v_cnt - VCW'(VA));
    rgb    = de_raw ? {x8, y8, 8'(x8 + y8)} : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
    end else begin
      hs_pipe <= {hs_pipe[PIPE_LAT-2:0], hs_raw};
      vs_pipe <= {vs_pipe[PIPE_LAT-2:0], vs_raw};
    end
  end

  assign VGA_hsync = hs_pipe[PIPE_LAT-1];
  assign VGA_vsync = vs_pipe[PIPE_LAT-1];

  hsi_video_rgb2hsi u_rgb2hsi (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (de_raw),
    .pix_rgb   (rgb),
    .hsi_valid (VGA_de),
    .hsi       (VGA_data)
  );
endmodule

// File: tb/tb_hsi_video_top.sv
// Bench for hsi_video_top: reset values, raster timing over one frame,
// pixel vectors at their exact output cycle, and asynchronous mid-line reset.
module tb_hsi_video_top;
  localparam int H_DISP = 400, V_DISP = 130;
  localparam int H_SYNC = 40, H_BACK = 20, H_FRONT = 20;
  localparam int V_SYNC = 2, V_BACK = 4, V_FRONT = 4;
  localparam int LAT      = 4;
  localparam int H_TOTAL  = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL  = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int FRAME    = H_TOTAL * V_TOTAL;
  localparam int FIRST_DE = (V_SYNC + V_BACK) * H_TOTAL + H_SYNC + H_BACK + LAT;
  localparam int NV       = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        VGA_hsync, VGA_vsync, VGA_de;
  logic [23:0] VGA_data;

  // Fewer lines than the default frame so a whole frame fits a short run.
  hsi_video_top #(
    .H_DISP(H_DISP), .V_DISP(V_DISP), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .H_FRONT(H_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_FRONT(V_FRONT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .VGA_hsync(VGA_hsync), .VGA_vsync(VGA_vsync),
    .VGA_data(VGA_data), .VGA_de(VGA_de)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h (%0d) want 0x%0h (%0d)", name, act, act, exp, exp);
  endtask

  typedef struct {
    int          x;
    int          y;
    logic [23:0] hsi;
  } vec_t;

  vec_t        vecs[NV];
  logic [23:0] got_data[NV];
  int          got_cyc[NV];
  bit          seen[NV];

  initial begin
    int px, py, de_cnt, run, runs, bad_run, first_de, gate_err;
    int hrun, hrun_err, hper_err, hfalls, last_hfall;
    int vrun, vrun_first, vfalls, vfall2;
    logic prev_de, prev_hs, prev_vs;
    logic [7:0] xb, yb;
    logic [23:0] exp_d, first_data;
    bit found;

    vecs[0] = '{0,   0,   24'h000000};
    vecs[1] = '{255, 0,   24'hD5FFAA};
    vecs[2] = '{10,  10,  24'hAB3F0D};
    vecs[3] = '{100, 50,  24'hC07F64};
    vecs[4] = '{50,  100, 24'h967F64};
    vecs[5] = '{200, 100, 24'h0F9D72};
    vecs[6] = '{128, 129, 24'h2BFC56};
    vecs[7] = '{128, 128, 24'h2BFF55};
    for (int i = 0; i < NV; i++) begin seen[i] = 0; got_data[i] = '0; got_cyc[i] = 0; end

    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("reset_hsync", VGA_hsync, 1);
    chk("reset_vsync", VGA_vsync, 1);
    chk("reset_de",    VGA_de,    0);
    chk("reset_data",  VGA_data,  0);
    rst_n = 1'b1;

    px = 0; py = 0; de_cnt = 0; run = 0; runs = 0; bad_run = 0; first_de = 0; gate_err = 0;
    hrun = 0; hrun_err = 0; hper_err = 0; hfalls = 0; last_hfall = -1;
    vrun = 0; vrun_first = -1; vfalls = 0; vfall2 = -1;
    prev_de = 0; prev_hs = 1; prev_vs = 1;
    while (cyc < FRAME + 200) begin
      @(negedge clk);
      if (VGA_de) begin
        de_cnt++;
        run++;
        if (first_de == 0) first_de = cyc;
        for (int i = 0; i < NV; i++)
          if (vecs[i].x == px && vecs[i].y == py && !seen[i]) begin
            seen[i] = 1; got_data[i] = VGA_data; got_cyc[i] = cyc;
          end
        px++;
        if (px == H_DISP) begin px = 0; py++; end
      end else begin
        if (prev_de) begin
          runs++;
          if (run != H_DISP) bad_run++;
          run = 0;
        end
        if (VGA_data != '0) gate_err++;
      end
      if (!VGA_hsync) begin
        hrun++;
        if (prev_hs) begin
          hfalls++;
          if (last_hfall >= 0 && cyc - last_hfall != H_TOTAL) hper_err++;
          last_hfall = cyc;
        end
      end else if (!prev_hs) begin
        if (hrun != H_SYNC) hrun_err++;
        hrun = 0;
      end
      if (!VGA_vsync) begin
        vrun++;
        if (prev_vs) begin
          vfalls++;
          if (vfalls == 2) vfall2 = cyc;
        end
      end else if (!prev_vs) begin
        if (vrun_first < 0) vrun_first = vrun;
        vrun = 0;
      end
      prev_de = VGA_de; prev_hs = VGA_hsync; prev_vs = VGA_vsync;
    end

    chk("first_de_cycle", first_de, FIRST_DE);
    chk("de_per_frame",   de_cnt,   H_DISP * V_DISP);
    chk("active_lines",   runs,     V_DISP);
    chk("short_lines",    bad_run,  0);
    chk("data_gating",    gate_err, 0);
    chk("hsync_width",    hrun_err, 0);
    chk("hsync_period",   hper_err, 0);
    chk("hsync_falls",    hfalls,   V_TOTAL + 1);
    chk("vsync_width",    vrun_first, V_SYNC * H_TOTAL);
    chk("vsync_period",   vfall2,   FRAME + LAT);

    for (int i = 0; i < NV; i++) begin
      xb = vecs[i].x[7:0];
      yb = vecs[i].y[7:0];
`ifdef HSI_BYPASS_EN
      exp_d = {xb, yb, 8'(xb + yb)};
`else
      exp_d = vecs[i].hsi;
`endif
      chk($sformatf("pix_seen(%0d,%0d)", xb, yb), seen[i], 1);
      chk($sformatf("pix_data(%0d,%0d)", xb, yb), got_data[i], exp_d);
      chk($sformatf("pix_cycle(%0d,%0d)", xb, yb), got_cyc[i],
          (V_SYNC + V_BACK + vecs[i].y) * H_TOTAL + H_SYNC + H_BACK + vecs[i].x + LAT);
    end

    // Catch a live non-black pixel, then pull reset between clock edges.
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clk);
      if (VGA_de && VGA_data != '0) found = 1;
    end
    chk("midline_pixel_found", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_hsync", VGA_hsync, 1);
    chk("async_vsync", VGA_vsync, 1);
    chk("async_de",    VGA_de,    0);
    chk("async_data",  VGA_data,  0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    first_de = 0;
    first_data = 24'hFFFFFF;
    for (int i = 0; i < FIRST_DE + 100 && first_de == 0; i++) begin
      @(negedge clk);
      if (VGA_de) begin first_de = cyc; first_data = VGA_data; end
    end
    chk("restart_first_de", first_de, FIRST_DE);
    chk("restart_first_pixel", first_data, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
